// File: rtl/mic_spi_capture.sv
// mic_spi_capture: SPI master that reads one 16-bit frame from a microphone
// ADC for each accepted sample request.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sample_req    frame request, level sampled every clk
//   MISO          serial data from the ADC, MSB first
//   SS            chip select to the ADC, active-low
//   SCK           serial clock to the ADC, idles high
//   data_raw      last complete 16-bit frame
//   sample_8b     data_raw[11:4], feeds the 8-bit DAC stage
//   sample_valid  one-clk pulse when data_raw/sample_8b update
//   hdr_err       last frame had a non-zero header nibble
//   busy          FSM is not in IDLE
//   overrun_cnt   requests dropped while busy, saturating at 255
//
// state | meaning
// IDLE  | SS high, SCK high, waiting for sample_req
// SETUP | SS low, SCK high for CLK_DIV cycles before the first clock
// SHIFT | 16 SCK periods, MISO captured at each SCK rising edge
// HOLD  | SS low, SCK high for CLK_DIV cycles after the last clock
// QUIET | SS high; publishes the frame on entry, then QUIET_CYC cycles

module mic_spi_capture #(
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_req,
    input  logic        MISO,
    output logic        SS,
    output logic        SCK,
    output logic [15:0] data_raw,
    output logic [7:0]  sample_8b,
    output logic        sample_valid,
    output logic        hdr_err,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

    localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
    // The publish cycle is counted on top of QUIET_CYC, hence no "- 1".
    localparam logic [7:0] QUIET_LD = 8'(QUIET_CYC);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [15:0] shreg, shreg_n;
    logic        ss_n, sck_n, valid_n, load;
    logic        drop;

    assign drop      = sample_req && (state != IDLE);
    assign sample_8b = data_raw[11:4];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ss_n      = SS;
        sck_n     = SCK;
        valid_n   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (sample_req) begin
                    state_n = SETUP;
                    cnt_n   = DIV_LD;
                    ss_n    = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_n   = SHIFT;
                    cnt_n     = DIV_LD;
                    sck_n     = 1'b0;
                    bit_cnt_n = 4'd15;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            SHIFT: begin
                if (cnt == 8'd0) begin
                    cnt_n = DIV_LD;
                    if (!SCK) begin
                        // end of low phase: sample as SCK rises
                        shreg_n = {shreg[14:0], MISO};
                        sck_n   = 1'b1;
                    end else if (bit_cnt == 4'd0) begin
                        state_n = HOLD;
                    end else begin
                        bit_cnt_n = bit_cnt - 4'd1;
                        sck_n     = 1'b0;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_n = QUIET;
                    cnt_n   = QUIET_LD;
                    ss_n    = 1'b1;
                    valid_n = 1'b1;
                    load    = 1'b1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            QUIET: begin
                if (cnt == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                ss_n    = 1'b1;
                sck_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            bit_cnt      <= 4'd0;
            shreg        <= 16'd0;
            SS           <= 1'b1;
            SCK          <= 1'b1;
            data_raw     <= 16'd0;
            sample_valid <= 1'b0;
            hdr_err      <= 1'b0;
            busy         <= 1'b0;
            overrun_cnt  <= 8'd0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            SS           <= ss_n;
            SCK          <= sck_n;
            sample_valid <= valid_n;
            busy         <= (state_n != IDLE);
            if (load) begin
                data_raw <= shreg;
                hdr_err  <= |shreg[15:12];
            end
            if (drop && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mic_spi_capture.sv
// Testbench for mic_spi_capture: a default-parameter instance (a) and a
// CLK_DIV=2 / QUIET_CYC=1 instance (b), each with an SPI-slave MISO model and
// a scoreboard of expected frames checked on every sample_valid pulse.

module tb_mic_spi_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, miso_a, ss_a, sck_a, valid_a, hdr_a, busy_a;
    logic [15:0] raw_a;
    logic [7:0]  s8_a, ovr_a;
    logic        req_b, miso_b, ss_b, sck_b, valid_b, hdr_b, busy_b;
    logic [15:0] raw_b;
    logic [7:0]  s8_b, ovr_b;

    always #5 clk = ~clk;

    mic_spi_capture dut_a (
        .clk(clk), .rst_n(rst_n), .sample_req(req_a), .MISO(miso_a),
        .SS(ss_a), .SCK(sck_a), .data_raw(raw_a), .sample_8b(s8_a),
        .sample_valid(valid_a), .hdr_err(hdr_a), .busy(busy_a),
        .overrun_cnt(ovr_a)
    );

    mic_spi_capture #(.CLK_DIV(2), .QUIET_CYC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_req(req_b), .MISO(miso_b),
        .SS(ss_b), .SCK(sck_b), .data_raw(raw_b), .sample_8b(s8_b),
        .sample_valid(valid_b), .hdr_err(hdr_b), .busy(busy_b),
        .overrun_cnt(ovr_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADC model: presents the MSB when SS falls, advances after each SCK rise
    logic [15:0] word_a = 16'h0000;
    logic [15:0] word_b = 16'h0000;
    int idx_a = 15, idx_b = 15, rises_a = 0, nfr_b = 0;
    logic [15:0] fast_words [0:2] = '{16'h0C3A, 16'h8001, 16'h07FE};

    always @(negedge ss_a) idx_a = 15;
    always @(posedge sck_a) if (!ss_a) begin idx_a = idx_a - 1; rises_a++; end
    assign miso_a = (idx_a >= 0) ? word_a[idx_a[3:0]] : 1'b0;

    always @(negedge ss_b) begin
        idx_b  = 15;
        word_b = fast_words[nfr_b % 3];
        nfr_b++;
    end
    always @(posedge sck_b) if (!ss_b) idx_b = idx_b - 1;
    assign miso_b = (idx_b >= 0) ? word_b[idx_b[3:0]] : 1'b0;

    typedef struct { logic [15:0] data; int at; } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    int valid_cnt_a = 0, valid_cnt_b = 0, stray_a = 0, stray_b = 0;
    logic [15:0] prev_raw_a, prev_raw_b;
    logic prev_hdr_a, prev_hdr_b;
    int hi_run_b = 0, min_gap_b = 1000;
    bit seen_low_b = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (valid_a) begin
                valid_cnt_a++;
                if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
                else begin
                    e = q_a.pop_front();
                    check("a_valid_cycle", cyc, e.at);
                    check("a_data_raw", raw_a, e.data);
                    check("a_sample_8b", s8_a, e.data[11:4]);
                    check("a_hdr_err", hdr_a, |e.data[15:12]);
                end
            end
            if (!valid_a && (raw_a !== prev_raw_a || hdr_a !== prev_hdr_a)) stray_a++;
            if (s8_a !== raw_a[11:4]) stray_a++;
        end
        prev_raw_a = raw_a;
        prev_hdr_a = hdr_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (valid_b) begin
                valid_cnt_b++;
                if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
                else begin
                    e = q_b.pop_front();
                    check("b_valid_cycle", cyc, e.at);
                    check("b_data_raw", raw_b, e.data);
                    check("b_hdr_err", hdr_b, |e.data[15:12]);
                end
            end
            if (!valid_b && (raw_b !== prev_raw_b || hdr_b !== prev_hdr_b)) stray_b++;
            if (s8_b !== raw_b[11:4]) stray_b++;
            if (ss_b) hi_run_b++;
            else begin
                if (seen_low_b && hi_run_b > 0 && hi_run_b < min_gap_b) min_gap_b = hi_run_b;
                hi_run_b   = 0;
                seen_low_b = 1;
            end
        end
        prev_raw_b = raw_b;
        prev_hdr_b = hdr_b;
    end

    // one default-parameter frame; loop index k is the cycle number
    task automatic single_frame(input logic [15:0] w);
        int first_low = -1;
        int last_low  = -1;
        word_a  = w;
        rises_a = 0;
        q_a.push_back('{data: w, at: cyc + 1 + 4 * 34});
        for (int k = 0; k < 150; k++) begin
            req_a = (k == 0);
            if (!ss_a) begin
                if (first_low < 0) first_low = k;
                last_low = k;
            end
            if (k == 1)   check("a_busy_setup", busy_a, 1);
            if (k == 145) check("a_busy_quiet", busy_a, 1);
            if (k == 146) check("a_busy_idle", busy_a, 0);
            tick();
        end
        check("a_ss_first_low", first_low, 1);
        check("a_ss_last_low", last_low, 136);
        check("a_sck_rises", rises_a, 16);
    endtask

    initial begin
        int vc0;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) tick();
        check("rst_ss", ss_a, 1);
        check("rst_sck", sck_a, 1);
        check("rst_data_raw", raw_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_hdr", hdr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_b_ss_sck", {ss_b, sck_b}, 2'b11);
        rst_n = 1'b1;
        repeat (20) tick();
        check("idle_no_frame", {ss_a, busy_a}, 2'b10);

        single_frame(16'h0A5C);
        single_frame(16'hF123);

        // overrun: pulse at 50, 3 cycles in QUIET, one at the QUIET->IDLE
        // transition (dropped), one in the first IDLE cycle (accepted)
        word_a = 16'h3C96;
        vc0 = valid_cnt_a;
        q_a.push_back('{data: 16'h3C96, at: cyc + 137});
        q_a.push_back('{data: 16'h3C96, at: cyc + 146 + 137});
        for (int k = 0; k < 300; k++) begin
            req_a = (k == 0) || (k == 50) || (k >= 140 && k <= 142) || (k == 145) || (k == 146);
            if (k == 144) begin
                check("a_overrun_4", ovr_a, 4);
                check("a_one_valid", valid_cnt_a - vc0, 1);
            end
            if (k == 146) check("a_first_idle_busy", busy_a, 0);
            if (k == 147) check("a_accept_first_idle", ss_a, 0);
            tick();
        end
        check("a_overrun_5", ovr_a, 5);
        check("a_two_valid", valid_cnt_a - vc0, 2);

        // reset mid-frame
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        word_a = 16'hFFFF;
        vc0 = valid_cnt_a;
        for (int k = 0; k <= 70; k++) begin
            req_a = (k == 0);
            if (k == 70) begin
                check("a_pre_abort_ss_sck", {ss_a, sck_a}, 2'b00);
                rst_n = 1'b0;
                #1;
                check("a_abort_ss_sck", {ss_a, sck_a}, 2'b11);
                check("a_abort_busy", busy_a, 0);
            end else begin
                tick();
            end
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (200) tick();
        check("a_abort_no_valid", valid_cnt_a - vc0, 0);
        check("a_abort_data_raw", raw_a, 0);
        check("a_abort_hdr", hdr_a, 0);

        // fast instance, request held for three frames
        for (int i = 0; i < 3; i++)
            q_b.push_back('{data: fast_words[(nfr_b + i) % 3], at: cyc + 71 * i + 1 + 2 * 34});
        for (int k = 0; k < 230; k++) begin
            req_b = (k <= 142);
            tick();
        end
        check("b_valid_count", valid_cnt_b, 3);
        check("b_overrun", ovr_b, 140);
        check("b_ss_gap", min_gap_b >= 1, 1);

        // saturation of overrun_cnt with a sustained request
        word_a = 16'h0A5C;
        for (int i = 0; i < 3; i++)
            q_a.push_back('{data: 16'h0A5C, at: cyc + 146 * i + 137});
        for (int k = 0; k < 440; k++) begin
            req_a = (k <= 292);
            if (k == 200) check("a_overrun_198", ovr_a, 198);
            tick();
        end
        check("a_overrun_sat", ovr_a, 255);

        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        check("a_stray_updates", stray_a, 0);
        check("b_stray_updates", stray_b, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
